dct_quant_zigzag: RTL and testbench
===================================

# dct_quant_zigzag

Quantizer and zigzag reorderer that sits directly downstream of the 8-point DCT stages. It starts when a full 8x8 block of signed 16-bit DCT coefficients is resident in the coefficient EBR. It fetches the coefficients in JPEG zigzag order and multiplies each by a reciprocal quantization value. Each result is rounded and saturated to 12 bits and handed to the entropy coder over a valid/ready handshake.

## Interface
- `COEF_WIDTH`, 16: signed coefficient width read from the coefficient EBR.
- `RECIP_WIDTH`, 16: unsigned reciprocal width, where recip = round(2^16 / Q).
- `OUT_WIDTH`, 12: signed quantized output width.
- `clock` in 1: single clock for the block.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse meaning a coefficient block is ready; ignored while `busy`.
- `busy` out 1: high from the accepted `start` until `done`.
- `fetch_addr` out 6: coefficient EBR read address, row-major index r*8+c.
- `fetch_clk` out 1: equals `clock`; drives the EBR `rclk`.
- `fetch_data` in COEF_WIDTH: EBR `dout`, signed.
- `recip_addr` out 6: reciprocal-table read address; always equal to `fetch_addr`.
- `recip_data` in RECIP_WIDTH: reciprocal-table `dout`, unsigned.
- `out_data` out OUT_WIDTH: quantized coefficient, signed.
- `out_index` out 6: zigzag position k of `out_data`.
- `out_valid` out 1: `out_data` and `out_index` are valid.
- `out_ready` in 1: the consumer accepts the word.
- `done` out 1: one-cycle pulse after the 64th handshake.

## Operation
- **FSM states:** IDLE → ADDR → READ → MULT → OUT → (ADDR or DONE) → IDLE.
- **IDLE:**
  - `start` high at an edge: k←0, `fetch_addr`←zz[0], `busy`←1, go to ADDR.
- **ADDR:** the EBR samples `fetch_addr` on this edge. Go to READ.
- **READ:** `fetch_data` and `recip_data` are valid this cycle.
  - Register p = coef × {1'b0, recip}, a 33-bit signed product.
  - Go to MULT.
- **MULT:** round and saturate p into `out_data`.
  - `out_index`←k, `out_valid`←1, go to OUT.
- **OUT:** hold `out_data`, `out_index` and `out_valid` until `out_valid && out_ready` at an edge.
  - On that edge `out_valid`←0.
  - If k==63: go to DONE.
  - Otherwise: k←k+1, `fetch_addr`←zz[k+1], go to ADDR.
- **DONE:** `done`=1 for this cycle only. `busy`←0, go to IDLE.
- **Rounding (half away from zero):**
  - q = (|p| + 2^15) >> 16.
  - Negate q when p<0.
- **Saturation:** clamp to [-2048, +2047].
- **Zigzag table zz[k]:** the standard JPEG order, starting 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,…; zz[63]=63. Implemented as a 64-entry constant case.
- **Boundary conditions:**
  - `start` while `busy`: ignored, with no effect on k or outputs.
  - `start` in the same cycle as `done`: ignored. A new block needs `start` while in IDLE.
  - Reset mid-block: abort immediately and return to IDLE. No `done` is issued. A partially emitted block is not resumed.
  - `recip_data`=0: output is 0.

## Timing
- **Reset values:**
  - `busy`=0, `done`=0, `out_valid`=0.
  - `out_data`=0, `out_index`=0.
  - `fetch_addr`=0, `recip_addr`=0.
  - State IDLE, k=0.
- **Read latency:** 1 cycle (registered EBR read on `fetch_clk`).
- **First word:** `start` sampled at edge e0 → `out_valid` high after edge e3.
- **Throughput:** 4 cycles per coefficient with `out_ready` held high.
  - `out_valid` is high 1 cycle in 4.
  - Handshake at e4 → next `out_valid` after e7.
- **Whole block** (`out_ready` always high):
  - Last handshake at edge e256.
  - `done` high in the cycle after e256.
  - `busy` low after e257.
- **Backpressure:** stall cycles are added 1:1. Outputs stay stable while `out_valid && !out_ready`.
- **`out_valid`:** never deasserts without a handshake, except on reset.

## Test plan
- **Uniform block:** all coef=100, all recip=6554 (Q=10) → 64 words, each `out_data`=10, `out_index`=0..63 in order. `done` pulses once; `busy` is low afterwards.
- **Zigzag order:** coef[i]=i, recip=65535 → `out_data` sequence 0,1,8,16,9,2,3,10,17,24,… with `out_index`=k.
- **Rounding and sign:**
  - coef=-15, recip=32768 → -8.
  - coef=+15, recip=32768 → 8.
  - coef=-14, recip=32768 → -7.
- **Saturation:**
  - coef=32767, recip=65535 → 2047.
  - coef=-32768, recip=65535 → -2048.
  - coef=0 → 0.
- **Backpressure and `start` while busy:**
  - Setup: all coef=100, all recip=6554; `out_ready` low for 10 cycles at word k=5; `start` pulsed mid-block.
  - `out_data`/`out_index` are held unchanged during the stall, no word is lost or duplicated, the extra `start` is ignored, and `done` comes 10 cycles late.
- **Reset mid-block:** assert `reset` after 20 words.
  - All outputs return to 0 asynchronously and `done` never pulses.
  - After a new `start`, a full 64-word block is emitted from k=0.

Source files
------------

// File: rtl/dct_quant_zigzag.sv
// dct_quant_zigzag
//
// Reads one 8x8 block of signed DCT coefficients from the coefficient EBR in
// JPEG zigzag order. Each coefficient is multiplied by a 16-bit reciprocal
// quantizer, rounded half away from zero, saturated to OUT_WIDTH bits and
// presented to the entropy coder one word at a time.
//
// Ports
//   clock, reset    : single clock, asynchronous active-high reset
//   start           : one-cycle pulse, a block is resident (ignored unless idle)
//   busy            : high from accepted start until the done cycle ends
//   done            : one-cycle pulse after the 64th accepted word
//   fetch_addr/clk  : coefficient EBR read port (registered read, 1 cycle)
//   fetch_data      : EBR dout, signed
//   recip_addr      : reciprocal table address, mirrors fetch_addr
//   recip_data      : reciprocal table dout, unsigned round(2^16/Q)
//   out_data        : quantized coefficient, signed
//   out_index       : zigzag position k of out_data
//   out_valid/ready : output handshake
//   state_dbg       : current FSM state, for observation only
//
// Handshake: out_valid, once raised, stays high with out_data and out_index
// frozen until a rising clock edge sees out_valid && out_ready; that edge is
// the transfer. out_valid only drops without a transfer on reset.

module dct_quant_zigzag #(
    parameter int COEF_WIDTH  = 16,
    parameter int RECIP_WIDTH = 16,
    parameter int OUT_WIDTH   = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic [5:0]             fetch_addr,
    output logic                   fetch_clk,
    input  logic [COEF_WIDTH-1:0]  fetch_data,
    output logic [5:0]             recip_addr,
    input  logic [RECIP_WIDTH-1:0] recip_data,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic [5:0]             out_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   done,
    output logic [2:0]             state_dbg
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_READ = 3'd2;
    localparam logic [2:0] S_MULT = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    // Product width: signed coefficient times zero-extended reciprocal.
    localparam int PW        = COEF_WIDTH + RECIP_WIDTH + 1;
    localparam int FRAC_BITS = 16;

    localparam logic [PW-1:0] PW_ONE     = PW'(1);
    localparam logic [PW-1:0] ROUND_HALF = PW_ONE << (FRAC_BITS - 1);
    localparam logic [PW-1:0] POS_LIMIT  = (PW_ONE << (OUT_WIDTH - 1)) - PW_ONE;
    localparam logic [PW-1:0] NEG_LIMIT  = PW_ONE << (OUT_WIDTH - 1);

    logic [2:0]           state_q, state_d;
    logic [5:0]           k_q, k_d;
    logic [5:0]           fetch_addr_q, fetch_addr_d;
    logic                 busy_q, busy_d;
    logic [PW-1:0]        prod_q, prod_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [5:0]           out_index_q, out_index_d;
    logic                 out_valid_q, out_valid_d;

    logic [PW-1:0]        coef_ext;
    logic [PW-1:0]        recip_ext;
    logic                 prod_neg;
    logic [PW-1:0]        prod_mag;
    logic [PW-1:0]        prod_rnd;
    logic [PW-1:0]        q_mag;
    logic [OUT_WIDTH-1:0] q_sat;

    // JPEG zigzag: position k -> row-major index r*8+c.
    function automatic logic [5:0] zz(input logic [5:0] k);
        logic [5:0] a;
        case (k)
            6'd0:  a = 6'd0;   6'd1:  a = 6'd1;   6'd2:  a = 6'd8;   6'd3:  a = 6'd16;
            6'd4:  a = 6'd9;   6'd5:  a = 6'd2;   6'd6:  a = 6'd3;   6'd7:  a = 6'd10;
            6'd8:  a = 6'd17;  6'd9:  a = 6'd24;  6'd10: a = 6'd32;  6'd11: a = 6'd25;
            6'd12: a = 6'd18;  6'd13: a = 6'd11;  6'd14: a = 6'd4;   6'd15: a = 6'd5;
            6'd16: a = 6'd12;  6'd17: a = 6'd19;  6'd18: a = 6'd26;  6'd19: a = 6'd33;
            6'd20: a = 6'd40;  6'd21: a = 6'd48;  6'd22: a = 6'd41;  6'd23: a = 6'd34;
            6'd24: a = 6'd27;  6'd25: a = 6'd20;  6'd26: a = 6'd13;  6'd27: a = 6'd6;
            6'd28: a = 6'd7;   6'd29: a = 6'd14;  6'd30: a = 6'd21;  6'd31: a = 6'd28;
            6'd32: a = 6'd35;  6'd33: a = 6'd42;  6'd34: a = 6'd49;  6'd35: a = 6'd56;
            6'd36: a = 6'd57;  6'd37: a = 6'd50;  6'd38: a = 6'd43;  6'd39: a = 6'd36;
            6'd40: a = 6'd29;  6'd41: a = 6'd22;  6'd42: a = 6'd15;  6'd43: a = 6'd23;
            6'd44: a = 6'd30;  6'd45: a = 6'd37;  6'd46: a = 6'd44;  6'd47: a = 6'd51;
            6'd48: a = 6'd58;  6'd49: a = 6'd59;  6'd50: a = 6'd52;  6'd51: a = 6'd45;
            6'd52: a = 6'd38;  6'd53: a = 6'd31;  6'd54: a = 6'd39;  6'd55: a = 6'd46;
            6'd56: a = 6'd53;  6'd57: a = 6'd60;  6'd58: a = 6'd61;  6'd59: a = 6'd54;
            6'd60: a = 6'd47;  6'd61: a = 6'd55;  6'd62: a = 6'd62;  6'd63: a = 6'd63;
            default: a = 6'd0;
        endcase
        return a;
    endfunction

    // Operands widened to the product width so the low PW bits of an
    // unsigned multiply are the exact two's-complement product.
    assign coef_ext  = {{(PW-COEF_WIDTH){fetch_data[COEF_WIDTH-1]}}, fetch_data};
    assign recip_ext = {{(PW-RECIP_WIDTH){1'b0}}, recip_data};

    // Round half away from zero on the magnitude, then restore sign and clamp.
    always_comb begin
        prod_neg = prod_q[PW-1];
        prod_mag = prod_neg ? (~prod_q + PW_ONE) : prod_q;
        prod_rnd = prod_mag + ROUND_HALF;
        q_mag    = prod_rnd >> FRAC_BITS;
        q_sat    = '0;
        if (prod_neg) begin
            if (q_mag > NEG_LIMIT) begin
                q_sat = OUT_WIDTH'(NEG_LIMIT);
            end else begin
                q_sat = OUT_WIDTH'(~q_mag + PW_ONE);
            end
        end else begin
            if (q_mag > POS_LIMIT) begin
                q_sat = OUT_WIDTH'(POS_LIMIT);
            end else begin
                q_sat = OUT_WIDTH'(q_mag);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        fetch_addr_d = fetch_addr_q;
        busy_d       = busy_q;
        prod_d       = prod_q;
        out_data_d   = out_data_q;
        out_index_d  = out_index_q;
        out_valid_d  = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d          = 6'd0;
                    fetch_addr_d = zz(6'd0);
                    busy_d       = 1'b1;
                    state_d      = S_ADDR;
                end
            end
            // The EBR registers fetch_addr on the edge leaving this state.
            S_ADDR: state_d = S_READ;
            S_READ: begin
                prod_d  = coef_ext * recip_ext;
                state_d = S_MULT;
            end
            S_MULT: begin
                out_data_d  = q_sat;
                out_index_d = k_q;
                out_valid_d = 1'b1;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (k_q == 6'd63) begin
                        state_d = S_DONE;
                    end else begin
                        k_d          = k_q + 6'd1;
                        fetch_addr_d = zz(k_q + 6'd1);
                        state_d      = S_ADDR;
                    end
                end
            end
            // start is not looked at here, so a start coincident with done is dropped.
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            k_q          <= 6'd0;
            fetch_addr_q <= 6'd0;
            busy_q       <= 1'b0;
            prod_q       <= '0;
            out_data_q   <= '0;
            out_index_q  <= 6'd0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            fetch_addr_q <= fetch_addr_d;
            busy_q       <= busy_d;
            prod_q       <= prod_d;
            out_data_q   <= out_data_d;
            out_index_q  <= out_index_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign fetch_clk  = clock;
    assign fetch_addr = fetch_addr_q;
    assign recip_addr = fetch_addr_q;
    assign busy       = busy_q;
    assign done       = (state_q == S_DONE);
    assign out_data   = out_data_q;
    assign out_index  = out_index_q;
    assign out_valid  = out_valid_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Testbench for dct_quant_zigzag: EBR and reciprocal table models, a
// scoreboard fed from a zigzag/quantization reference model, and directed
// plus randomized blocks with backpressure, spurious start and reset.

module tb_dct_quant_zigzag;

    localparam int CW = 16;
    localparam int RW = 16;
    localparam int OW = 12;
    localparam int EW = OW + 6;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic [5:0]    fetch_addr;
    logic          fetch_clk;
    logic [CW-1:0] fetch_data;
    logic [5:0]    recip_addr;
    logic [RW-1:0] recip_data;
    logic [OW-1:0] out_data;
    logic [5:0]    out_index;
    logic          out_valid;
    logic          out_ready;
    logic          done;
    logic [2:0]    state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int words_seen = 0;
    int ready_mode = 0;   // 0: always ready, 1: random, 2: driven by a task

    logic [CW-1:0] coef_mem [64];
    logic [RW-1:0] recip_mem [64];
    int            zz_ref [64];
    logic [EW-1:0] exp_q [$];

    dct_quant_zigzag dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .fetch_addr (fetch_addr),
        .fetch_clk  (fetch_clk),
        .fetch_data (fetch_data),
        .recip_addr (recip_addr),
        .recip_data (recip_data),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset / memories ----------------
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Registered-read EBR and reciprocal ROM, one cycle latency.
    always @(posedge fetch_clk) begin
        fetch_data <= coef_mem[fetch_addr];
        recip_data <= recip_mem[recip_addr];
    end

    always begin
        @(posedge clock);
        #1;
        if (ready_mode == 0) out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
    end

    // ---------------- reference model ----------------
    // Zigzag walks anti-diagonals s=r+c; even s goes up (row decreasing),
    // odd s goes down (row increasing).
    function automatic void build_zz();
        int idx;
        int lo;
        int hi;
        idx = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz_ref[idx] = r * 8 + (s - r);
                    idx++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz_ref[idx] = r * 8 + (s - r);
                    idx++;
                end
            end
        end
    endfunction

    function automatic logic [OW-1:0] quant_ref(input int coef, input int recip);
        longint p;
        longint a;
        longint q;
        p = longint'(coef) * longint'(recip);
        a = (p < 0) ? -p : p;
        q = (a + 32768) / 65536;
        if (p < 0) q = -q;
        if (q > 2047) q = 2047;
        if (q < -2048) q = -2048;
        return q[OW-1:0];
    endfunction

    task automatic push_block();
        int a;
        logic [OW-1:0] v;
        for (int k = 0; k < 64; k++) begin
            a = zz_ref[k];
            v = quant_ref(int'($signed(coef_mem[a])), int'(recip_mem[a]));
            exp_q.push_back({6'(k), v});
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_word got idx %0d data %0d, none expected",
                         out_index, $signed(out_data));
            end else begin
                if ({out_index, out_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL word got idx %0d data %0d exp idx %0d data %0d",
                             out_index, $signed(out_data),
                             exp_q[0][EW-1:OW], $signed(exp_q[0][OW-1:0]));
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    words_seen++;
                end
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    // exp_lat > 0 checks the start-to-done cycle count.
    task automatic run_block(input string name, input int exp_lat, input bit start_at_done);
        int t0;
        int d0;
        int n;
        d0 = done_cnt;
        push_block();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        t0 = cyc;
        n = 0;
        while (!done && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (start_at_done) start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        check({name, "_done_count"}, done_cnt - d0, 1);
        if (exp_lat > 0) check({name, "_latency"}, done_cyc - t0, exp_lat);
        check({name, "_busy_after"}, int'(busy), 0);
        check({name, "_words_left"}, exp_q.size(), 0);
        exp_q.delete();
        if (start_at_done) begin
            repeat (12) @(posedge clock);
            #1;
            check({name, "_restart_ignored_busy"}, int'(busy), 0);
            check({name, "_restart_ignored_done"}, done_cnt - d0, 1);
        end
    endtask

    task automatic stall_and_poke();
        int n;
        n = 0;
        ready_mode = 2;
        out_ready = 1'b1;
        while (n < 200) begin
            @(posedge clock);
            #1;
            if (out_valid && out_index == 6'd5) break;
            n++;
        end
        check("stall_reached_k5", int'(out_valid && out_index == 6'd5), 1);
        out_ready = 1'b0;
        repeat (10) @(posedge clock);
        #1 out_ready = 1'b1;
        repeat (30) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        ready_mode = 0;
    endtask

    task automatic fill_uniform(input int c, input int r);
        for (int i = 0; i < 64; i++) begin
            coef_mem[i]  = CW'(c);
            recip_mem[i] = RW'(r);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            case ($urandom_range(0, 5))
                0: coef_mem[i] = 16'h7fff;
                1: coef_mem[i] = 16'h8000;
                default: coef_mem[i] = CW'($urandom);
            endcase
            recip_mem[i] = ($urandom_range(0, 7) == 0) ? 16'd0 : RW'($urandom);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_done"}, int'(done), 0);
        check({name, "_out_valid"}, int'(out_valid), 0);
        check({name, "_out_data"}, int'(out_data), 0);
        check({name, "_out_index"}, int'(out_index), 0);
        check({name, "_fetch_addr"}, int'(fetch_addr), 0);
        check({name, "_recip_addr"}, int'(recip_addr), 0);
        check({name, "_state"}, int'(state_dbg), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w0;
        int d0;
        int n;
        build_zz();
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        fill_uniform(0, 0);
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock) reset = 1'b0;

        // Uniform block; a start coincident with done must be dropped.
        fill_uniform(100, 6554);
        run_block("uniform", 256, 1'b1);

        // Zigzag order: coef[i]=i, recip ~ 1.0.
        for (int i = 0; i < 64; i++) begin
            coef_mem[i]  = CW'(i);
            recip_mem[i] = 16'd65535;
        end
        run_block("zigzag", 256, 1'b0);

        // Rounding, sign, saturation and zero-reciprocal corner cases.
        fill_random();
        coef_mem[0] = -16'sd15;   recip_mem[0] = 16'd32768;
        coef_mem[1] = 16'sd15;    recip_mem[1] = 16'd32768;
        coef_mem[8] = -16'sd14;   recip_mem[8] = 16'd32768;
        coef_mem[16] = 16'h7fff;  recip_mem[16] = 16'd65535;
        coef_mem[9] = 16'h8000;   recip_mem[9] = 16'd65535;
        coef_mem[2] = 16'd0;      recip_mem[2] = 16'd40000;
        coef_mem[3] = 16'd1234;   recip_mem[3] = 16'd0;
        coef_mem[10] = -16'sd1;   recip_mem[10] = 16'd32768;
        run_block("corners", 256, 1'b0);

        // Backpressure at k=5 plus a start pulse mid-block.
        fill_uniform(100, 6554);
        fork
            run_block("stall", 266, 1'b0);
            stall_and_poke();
        join

        // Random data with random backpressure.
        ready_mode = 1;
        for (int b = 0; b < 2; b++) begin
            fill_random();
            run_block("random", 0, 1'b0);
        end
        ready_mode = 0;

        // Reset after 20 words: everything clears at once, no done.
        fill_random();
        d0 = done_cnt;
        w0 = words_seen;
        push_block();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        n = 0;
        while (words_seen - w0 < 20 && n < 500) begin
            @(posedge clock);
            n++;
        end
        check("midreset_words", words_seen - w0, 20);
        #1 reset = 1'b1;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("midreset_no_done", done_cnt - d0, 0);
        check("midreset_idle_busy", int'(busy), 0);
        run_block("after_reset", 256, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400us;
        errors++;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
